dyn_phase_shift_ctrl: RTL and testbench

Sequencer for the dynamic fine phase shift port of the PLL/MMCM simulation models. It accepts a signed target phase offset, expressed in fine-shift steps, from a requester. It then issues the required number of single-step increment/decrement pulses on the PSEN/PSINCDEC/PSDONE handshake and tracks the accumulated shift. It sits between the testbench or a configuration master and the PLL model, in the PSCLK domain, and the per-output phase checkers measure its results.

---
 rtl/ps_ctrl_pkg.sv | 26 ++
 rtl/ps_watchdog.sv | 33 +++
 rtl/dyn_phase_shift_ctrl.sv | 147 ++++++++++++++
 tb/tb_dyn_phase_shift_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_ctrl_pkg.sv
// Shared types, default sizes and the target clamp helper for the
// dynamic fine phase shift sequencer.
package ps_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } ps_state_e;

    localparam int DEF_SHIFT_W   = 16;
    localparam int DEF_MAX_STEPS = 1120;

    // Saturate a signed step count to +/-lim. Works on 32-bit ints so the
    // caller sign-extends its SHIFT_W value first and truncates the result.
    function automatic int clamp_steps(input int v, input int lim);
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/ps_watchdog.sv
// Cycle counter that flags the LIMIT-th consecutive enabled cycle.
// Used only when PS_TIMEOUT_EN is defined to bound the wait for psdone.
module ps_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles; clear has priority so each wait starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_W'(LIMIT - 1))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Expire during the LIMIT-th enabled cycle (count starts at 0 in the first).
    always_comb begin
        expire = en && (cnt_q == CNT_W'(LIMIT - 1));
    end

endmodule

// File: rtl/dyn_phase_shift_ctrl.sv
// Dynamic fine phase shift sequencer. Accepts a signed target (in steps),
// clamps it to +/-MAX_STEPS and walks cur_shift toward it one PSEN/PSDONE
// step at a time. Optional psdone watchdog: define PS_TIMEOUT_EN.
//
// Request handshake: a target transfers on a rising clk edge where
// req_valid && req_ready are both high. req_ready depends only on state and
// locked (never on req_valid); once accepted the request is consumed and the
// requester may change req_target freely.
module dyn_phase_shift_ctrl
    import ps_ctrl_pkg::*;
#(
    parameter int SHIFT_W        = DEF_SHIFT_W,
    parameter int MAX_STEPS      = DEF_MAX_STEPS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      locked,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic signed [SHIFT_W-1:0] req_target,
    output logic                      psen,
    output logic                      psincdec,
    input  logic                      psdone,
    output logic signed [SHIFT_W-1:0] cur_shift,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                dbg_state
);

    ps_state_e                 state_q, state_d;
    logic signed [SHIFT_W-1:0] tgt_q, tgt_d;
    logic signed [SHIFT_W-1:0] cur_d;
    logic                      psen_d, psincdec_d, done_d, err_d;
    logic                      accept;
    logic                      wd_expire;

`ifdef PS_TIMEOUT_EN
    ps_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != WAIT_DONE),
        .en     (state_q == WAIT_DONE),
        .expire (wd_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign wd_expire          = 1'b0;
`endif

    // Handshake and status decode straight from the state register.
    always_comb begin
        req_ready = (state_q == IDLE) && locked;
        accept    = req_valid && req_ready;
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

    // Next-state and next-output logic; loss of lock overrides everything.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cur_d      = cur_shift;
        psen_d     = 1'b0;
        psincdec_d = psincdec;
        done_d     = 1'b0;
        err_d      = err;
        if (!locked) begin
            state_d = IDLE;
            cur_d   = '0;
            if (state_q != IDLE) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tgt_d = SHIFT_W'(clamp_steps(int'(req_target), MAX_STEPS));
                        err_d = 1'b0;
                        if (tgt_d == cur_shift) begin
                            done_d = 1'b1;
                        end else begin
                            state_d    = ISSUE;
                            psen_d     = 1'b1;
                            psincdec_d = (tgt_d > cur_shift);
                        end
                    end
                    if (psdone) begin
                        err_d = 1'b1;
                    end
                end
                ISSUE: begin
                    state_d = WAIT_DONE;
                    if (psdone) begin
                        err_d = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (psdone) begin
                        cur_d = psincdec ? (cur_shift + SHIFT_W'(1))
                                         : (cur_shift - SHIFT_W'(1));
                        if (cur_d == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ISSUE;
                            psen_d     = 1'b1;
                            psincdec_d = (tgt_q > cur_d);
                        end
                    end else if (wd_expire) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; async reset returns everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            cur_shift <= '0;
            psen      <= 1'b0;
            psincdec  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_shift <= cur_d;
            psen      <= psen_d;
            psincdec  <= psincdec_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_dyn_phase_shift_ctrl.sv
// Directed bench for dyn_phase_shift_ctrl with a simple PLL psdone responder.
module tb_dyn_phase_shift_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               locked = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic signed [15:0] req_target = '0;
    logic               psen;
    logic               psincdec;
    logic               psdone;
    logic signed [15:0] cur_shift;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         dbg_state;

    logic pll_done = 1'b0;
    logic stray_done = 1'b0;
    logic pll_en = 1'b1;
    int   pll_delay = 12;
    int   pend = 0;

    int n_checks = 0;
    int n_fail = 0;
    int n_inc = 0;
    int n_dec = 0;
    int n_done = 0;
    int n_space_viol = 0;
    int since = 100;
    logic [15:0] last_cur = '0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    assign psdone = pll_done | stray_done;

    dyn_phase_shift_ctrl #(
        .SHIFT_W        (16),
        .MAX_STEPS      (1120),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .psen       (psen),
        .psincdec   (psincdec),
        .psdone     (psdone),
        .cur_shift  (cur_shift),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // PLL model: returns psdone pll_delay cycles after each psen
    always @(negedge clk) begin
        pll_done = 1'b0;
        if (rst || !locked) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) pll_done = 1'b1;
            end
            if (psen && pll_en) pend = pll_delay;
        end
    end

    // monitor: step counts, done pulses, psen spacing, cur_shift history
    always @(negedge clk) begin
        if (psen) begin
            if (psincdec) n_inc++;
            else n_dec++;
            if (since == 0) n_space_viol++;
            since = 0;
        end else if (since < 100) begin
            since++;
        end
        if (done) n_done++;
        if (cur_shift !== last_cur) begin
            obs_q.push_back(cur_shift);
            last_cur = cur_shift;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_inc = 0;
        n_dec = 0;
        n_done = 0;
        obs_q.delete();
    endtask

    task automatic send_req(input logic signed [15:0] t);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_req_ready: req_ready=%b want 1", req_ready);
        end
        req_valid  = 1'b1;
        req_target = t;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int cnt = 0;
        while (n_done == 0 && cnt < budget) begin
            step();
            cnt++;
        end
        n_checks++;
        if (n_done == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({psen, psincdec, done, err, busy, req_ready} !== 6'b000001 || cur_shift !== 16'sd0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values: psen=%b inc=%b done=%b err=%b busy=%b rdy=%b cur=%0d st=%0d want 0 0 0 0 0 1 0 0",
                     psen, psincdec, done, err, busy, req_ready, cur_shift, dbg_state);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_inc();
        clear_counts();
        pll_delay = 12;
        send_req(16'sd3);
        n_checks++;
        if (psen !== 1'b1 || psincdec !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_first_psen: psen=%b inc=%b want 1 1", psen, psincdec);
        end
        wait_done(200, "inc");
        step();
        exp_q = '{16'd1, 16'd2, 16'd3};
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL inc_history_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL inc_history[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (n_inc != 3 || n_dec != 0 || n_done != 1 || err !== 1'b0 || cur_shift !== 16'sd3) begin
            n_fail++;
            $display("FAIL inc_summary: inc=%0d dec=%0d done=%0d err=%b cur=%0d want 3 0 1 0 3",
                     n_inc, n_dec, n_done, err, cur_shift);
        end
    endtask

    task automatic test_dec();
        clear_counts();
        send_req(-16'sd2);
        wait_done(200, "dec");
        step();
        exp_q = '{16'd2, 16'd1, 16'd0, 16'hFFFF, 16'hFFFE};
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL dec_history_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL dec_history[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (n_inc != 0 || n_dec != 5 || n_done != 1 || cur_shift !== -16'sd2) begin
            n_fail++;
            $display("FAIL dec_summary: inc=%0d dec=%0d done=%0d cur=%0d want 0 5 1 -2",
                     n_inc, n_dec, n_done, cur_shift);
        end
    endtask

    task automatic test_zero_delta();
        clear_counts();
        send_req(-16'sd2);
        n_checks++;
        if (done !== 1'b1 || psen !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_cycle1: done=%b psen=%b busy=%b want 1 0 0", done, psen, busy);
        end
        step();
        step();
        n_checks++;
        if (done !== 1'b0 || n_done != 1 || (n_inc + n_dec) != 0 || cur_shift !== -16'sd2) begin
            n_fail++;
            $display("FAIL zero_after: done=%b ndone=%0d steps=%0d cur=%0d want 0 1 0 -2",
                     done, n_done, n_inc + n_dec, cur_shift);
        end
    endtask

    task automatic test_clamp();
        clear_counts();
        n_space_viol = 0;
        pll_delay = 2;
        send_req(16'sd5000);
        wait_done(6000, "clamp");
        step();
        n_checks++;
        if (cur_shift !== 16'sd1120 || n_inc != 1122 || n_dec != 0 || n_done != 1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_summary: cur=%0d inc=%0d dec=%0d done=%0d err=%b want 1120 1122 0 1 0",
                     cur_shift, n_inc, n_dec, n_done, err);
        end
        n_checks++;
        if (n_space_viol != 0) begin
            n_fail++;
            $display("FAIL psen_spacing: back-to-back psen seen %0d times want 0", n_space_viol);
        end
    endtask

    task automatic test_async_reset();
        int cnt = 0;
        send_req(16'sd1110);
        while (cur_shift !== 16'sd1118 && cnt < 100) begin
            step();
            cnt++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (cur_shift !== 16'sd0 || psen !== 1'b0 || busy !== 1'b0 || psincdec !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cur=%0d psen=%b busy=%b inc=%b err=%b want 0 0 0 0 0",
                     cur_shift, psen, busy, psincdec, err);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_lock_loss();
        int cnt = 0;
        clear_counts();
        pll_delay = 12;
        send_req(16'sd10);
        while (cur_shift !== 16'sd2 && cnt < 200) begin
            step();
            cnt++;
        end
        locked = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || cur_shift !== 16'sd0 || err !== 1'b1 || psen !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_loss: busy=%b cur=%0d err=%b psen=%b rdy=%b want 0 0 1 0 0",
                     busy, cur_shift, err, psen, req_ready);
        end
        repeat (5) step();
        n_checks++;
        if (req_ready !== 1'b0 || n_done != 0 || cur_shift !== 16'sd0) begin
            n_fail++;
            $display("FAIL lock_hold: rdy=%b done=%0d cur=%0d want 0 0 0", req_ready, n_done, cur_shift);
        end
        locked = 1'b1;
        step();
        send_req(16'sd0);
        n_checks++;
        if (err !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_req: err=%b done=%b want 0 1", err, done);
        end
        step();
    endtask

    task automatic test_stray_psdone();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step();
        n_checks++;
        if (err !== 1'b1 || cur_shift !== 16'sd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_psdone: err=%b cur=%0d busy=%b want 1 0 0", err, cur_shift, busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        pll_delay = 3;
        send_req(16'sd1);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err_clear: err=%b want 0", err);
        end
        wait_done(100, "b2b_first");
        n_done = 0;
        send_req(-16'sd1);
        wait_done(100, "b2b_second");
        step();
        n_checks++;
        if (cur_shift !== -16'sd1 || n_inc != 1 || n_dec != 2) begin
            n_fail++;
            $display("FAIL b2b_summary: cur=%0d inc=%0d dec=%0d want -1 1 2", cur_shift, n_inc, n_dec);
        end
    endtask

`ifdef PS_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        clear_counts();
        pll_en = 1'b0;
        send_req(16'sd5);
        while (busy === 1'b1 && cnt < 300) begin
            step();
            cnt++;
        end
        n_checks++;
        if (cnt != 65 || err !== 1'b1 || cur_shift !== -16'sd1 || n_done != 0) begin
            n_fail++;
            $display("FAIL timeout: busy_cycles=%0d err=%b cur=%0d done=%0d want 65 1 -1 0",
                     cnt, err, cur_shift, n_done);
        end
        pll_en = 1'b1;
        send_req(16'sd0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover: err=%b want 0", err);
        end
        wait_done(200, "timeout_recover");
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_inc();
        test_dec();
        test_zero_delta();
        test_clamp();
        test_async_reset();
        test_lock_loss();
        test_stray_psdone();
        test_back_to_back();
`ifdef PS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
